// File: rtl/mul_acc_ctrl.sv
// mul_acc_ctrl: issue/accumulate controller around a fixed-latency, non-stalling
// 16x16 signed multiplier. Operand pairs are handed to the multiplier when they are
// accepted. A tag line of the same depth marks which multiplier result cycles carry
// real products and which of those close a group. Finished group sums are queued in a
// small output FIFO. Because the multiplier cannot be stalled, op_ready is a credit
// check: every group end still in the pipe already holds a FIFO slot.
//
// Group FSM
//   state     | meaning
//   GRP_FIRST | next exiting product starts a new group (accumulator treated as 0)
//   GRP_ACCUM | at least one product of the current group is already in acc
module mul_acc_ctrl #(
    parameter int MUL_LAT    = 2,
    parameter int ACC_W      = 40,
    parameter int FIFO_DEPTH = 4,
    parameter bit SAT        = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    input  logic             op_last,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    input  logic [31:0]      mul_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + MUL_LAT + 1) + 1;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [0:0] {
        GRP_FIRST = 1'b0,
        GRP_ACCUM = 1'b1
    } grp_state_t;

    grp_state_t grp_state;
    grp_state_t grp_next;

    // Issue side
    logic accept;
    logic last_issue;

    // Tag line aligned with the multiplier pipeline
    logic [MUL_LAT-1:0] tag_v;
    logic [MUL_LAT-1:0] tag_last;
    logic               exit_v;
    logic               exit_last;

    // Accumulator datapath
    logic [ACC_W-1:0] acc;
    logic             ovf_grp;
    logic             grp_first;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   sum_ext;
    logic             ovf_now;
    logic             ovf_sum;
    logic [ACC_W-1:0] sum_val;
    logic             acc_load;
    logic             fifo_push;

    // Output FIFO and credit bookkeeping
    logic [ACC_W-1:0]      fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_ovf;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [CNT_W-1:0]      lasts_in_flight;
    logic [CNT_W:0]        credit_used;
    logic                  fifo_pop;
    logic                  last_exit;

    // Operands go straight to the multiplier; it samples them only on accept cycles
    // as far as this controller is concerned, the tag line ignores everything else.
    assign mul_a = op_a;
    assign mul_b = op_b;

    // Credit check uses only registered counts so op_ready never depends on op_valid.
    always_comb begin
        credit_used = (CNT_W+1)'(fifo_cnt) + (CNT_W+1)'(lasts_in_flight);
        op_ready    = credit_used < (CNT_W+1)'(FIFO_DEPTH);
    end

    assign accept     = op_valid & op_ready;
    assign last_issue = accept & op_last;

    // Tag shift register: one entry per multiplier stage, bubbles carry v=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v    <= '0;
            tag_last <= '0;
        end else begin
            tag_v[0]    <= accept;
            tag_last[0] <= last_issue;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_v[i]    <= tag_v[i-1];
                tag_last[i] <= tag_last[i-1];
            end
        end
    end

    assign exit_v    = tag_v[MUL_LAT-1];
    assign exit_last = tag_v[MUL_LAT-1] & tag_last[MUL_LAT-1];
    assign last_exit = exit_last;

    // Group FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grp_state <= GRP_FIRST;
        end else begin
            grp_state <= grp_next;
        end
    end

    // Group FSM next state: a closing product pushes, any other product accumulates.
    always_comb begin
        grp_next  = grp_state;
        acc_load  = 1'b0;
        fifo_push = 1'b0;
        if (exit_v) begin
            if (exit_last) begin
                fifo_push = 1'b1;
                grp_next  = GRP_FIRST;
            end else begin
                acc_load  = 1'b1;
                grp_next  = GRP_ACCUM;
            end
        end
    end

    assign grp_first = (grp_state == GRP_FIRST);

    // Signed add with one guard bit; overflow is a disagreement between the guard
    // bit and the sign bit of the ACC_W-wide result.
    always_comb begin
        prod_ext = {{(ACC_W-32){mul_result[31]}}, mul_result};
        acc_base = grp_first ? '0 : acc;
        sum_ext  = {acc_base[ACC_W-1], acc_base} + {prod_ext[ACC_W-1], prod_ext};
        ovf_now  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
        ovf_sum  = (grp_first ? 1'b0 : ovf_grp) | ovf_now;
        sum_val  = sum_ext[ACC_W-1:0];
        if (ovf_now && SAT) begin
            sum_val = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Running sum and sticky overflow for the open group; cleared when it closes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            ovf_grp <= 1'b0;
        end else if (acc_load) begin
            acc     <= sum_val;
            ovf_grp <= ovf_sum;
        end else if (fifo_push) begin
            acc     <= '0;
            ovf_grp <= 1'b0;
        end
    end

    // Group ends between issue and multiplier output; each one reserves a FIFO slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lasts_in_flight <= '0;
        end else begin
            case ({last_issue, last_exit})
                2'b10:   lasts_in_flight <= lasts_in_flight + 1'b1;
                2'b01:   lasts_in_flight <= lasts_in_flight - 1'b1;
                default: lasts_in_flight <= lasts_in_flight;
            endcase
        end
    end

    assign res_valid = (fifo_cnt != '0);
    assign fifo_pop  = res_valid & res_ready;

    // FIFO storage; no reset needed since contents are only visible behind res_valid.
    // When full with a simultaneous pop, wr_ptr equals rd_ptr and the head is
    // overwritten exactly as it leaves.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data[wr_ptr] <= sum_val;
            fifo_ovf[wr_ptr]  <= ovf_sum;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Head of queue, forced to zero while empty.
    always_comb begin
        res_data = '0;
        res_ovf  = 1'b0;
        if (res_valid) begin
            res_data = fifo_data[rd_ptr];
            res_ovf  = fifo_ovf[rd_ptr];
        end
    end

endmodule

// File: tb/tb_mul_acc_ctrl.sv
// Bench for mul_acc_ctrl: a behavioural 2-stage multiplier feeds each DUT, expected
// group results are queued when the closing pair is accepted and checked as they leave.
module tb_mul_acc_ctrl;

    localparam int MUL_LAT = 2;

    logic clk;
    logic rst_n;

    // Main DUT (ACC_W=40, SAT=1)
    logic        op_valid, op_ready, op_last;
    logic [15:0] op_a, op_b, mul_a, mul_b;
    logic [31:0] mul_result;
    logic        res_valid, res_ready, res_ovf;
    logic [39:0] res_data;

    // Narrow DUT (ACC_W=33, SAT=1) for saturation at the minimum width
    logic        v2, rdy2, l2;
    logic [15:0] a2, b2, ma2, mb2;
    logic [31:0] mr2;
    logic        rv2, rr2, ro2;
    logic [32:0] rd2;

    int tests = 0;
    int fails = 0;
    int accepts = 0;

    typedef struct {
        logic [39:0] data;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        last;
        int          gap;
        logic [39:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[8];

    mul_acc_ctrl #(.MUL_LAT(2), .ACC_W(40), .FIFO_DEPTH(4), .SAT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_last(op_last),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_ovf(res_ovf)
    );

    mul_acc_ctrl #(.MUL_LAT(2), .ACC_W(33), .FIFO_DEPTH(4), .SAT(1'b1)) dut33 (
        .clk(clk), .rst_n(rst_n),
        .op_valid(v2), .op_ready(rdy2),
        .op_a(a2), .op_b(b2), .op_last(l2),
        .mul_a(ma2), .mul_b(mb2), .mul_result(mr2),
        .res_valid(rv2), .res_ready(rr2),
        .res_data(rd2), .res_ovf(ro2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multipliers: two register stages, sharing the synchronous reset.
    logic [31:0] p1, p2, q1, q2;
    always @(posedge clk) begin
        if (!rst_n) begin
            p1 <= '0; p2 <= '0; q1 <= '0; q2 <= '0;
        end else begin
            p1 <= {{16{mul_a[15]}}, mul_a} * {{16{mul_b[15]}}, mul_b};
            p2 <= p1;
            q1 <= {{16{ma2[15]}}, ma2} * {{16{mb2[15]}}, mb2};
            q2 <= q1;
        end
    end
    assign mul_result = p2;
    assign mr2        = q2;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    // Scoreboard consumer for the main DUT.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {24'd0, res_data}, 64'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("res_data", {24'd0, res_data}, {24'd0, e.data});
                chk("res_ovf", {63'd0, res_ovf}, {63'd0, e.ovf});
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last,
                        input logic [39:0] ed, input logic eo);
        int guard;
        guard = 0;
        op_valid = 1'b1; op_a = a; op_b = b; op_last = last;
        @(negedge clk);
        while (!op_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (op_ready) begin
            accepts++;
            if (last) sb.push_back('{ed, eo});
        end else begin
            chk("send_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        op_valid = 1'b0; op_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || res_valid) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", {63'd0, (sb.size() == 0 && !res_valid)}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic send2(input logic [15:0] a, input logic [15:0] b, input logic last);
        v2 = 1'b1; a2 = a; b2 = b; l2 = last;
        @(negedge clk);
        chk("dut33_ready", {63'd0, rdy2}, 64'd1);
        @(posedge clk); #1;
        v2 = 1'b0; l2 = 1'b0;
    endtask

    task automatic expect2(input string name, input logic [32:0] ed, input logic eo);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!rv2 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({name, "_valid"}, {63'd0, rv2}, 64'd1);
        chk({name, "_data"}, {31'd0, rd2}, {31'd0, ed});
        chk({name, "_ovf"}, {63'd0, ro2}, {63'd0, eo});
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int pa, pb;

        // Closing pairs carry the expected group result.
        vecs[0] = '{16'h7FFF, 16'h7FFF, 1'b1, 0, 40'h00_3FFF_0001, 1'b0};
        vecs[1] = '{16'h8000, 16'h8000, 1'b1, 0, 40'h00_4000_0000, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b1, 0, 40'(-1),          1'b0};
        vecs[3] = '{16'd100,  16'(-3),  1'b0, 2, 40'd0,            1'b0};
        vecs[4] = '{16'(-5),  16'(-5),  1'b1, 1, 40'(-275),        1'b0};
        vecs[5] = '{16'h8000, 16'h7FFF, 1'b0, 0, 40'd0,            1'b0};
        vecs[6] = '{16'h8000, 16'h7FFF, 1'b1, 3, 40'(-2147418112), 1'b0};
        vecs[7] = '{16'd9,    16'd11,   1'b1, 0, 40'd99,           1'b0};

        rst_n = 1'b0;
        op_valid = 1'b0; op_last = 1'b0; op_a = 16'h1234; op_b = 16'hA5C3;
        res_ready = 1'b1;
        v2 = 1'b0; l2 = 1'b0; a2 = 16'h0F0F; b2 = 16'h00FF; rr2 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_op_ready", {63'd0, op_ready}, 64'd1);
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_res_data", {24'd0, res_data}, 64'd0);
        chk("rst_res_ovf", {63'd0, res_ovf}, 64'd0);
        chk("rst_mul_a", {48'd0, mul_a}, 64'h1234);
        chk("rst_mul_b", {48'd0, mul_b}, 64'hA5C3);
        chk("rst_dut33_valid", {63'd0, rv2}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Three-pair group; result appears MUL_LAT+1 cycles after the closing accept.
        send(16'd3, 16'd4, 1'b0, 40'd0, 1'b0);
        send(16'd5, 16'd6, 1'b0, 40'd0, 1'b0);
        send(16'(-7), 16'd2, 1'b1, 40'd28, 1'b0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!res_valid && k < 10);
        chk("latency", 64'(k), 64'(MUL_LAT + 1));
        @(posedge clk); #1;
        drain();

        // Table vectors, including back-to-back single-pair groups and bubbles.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].last, vecs[i].exp_data, vecs[i].exp_ovf);
            if (vecs[i].gap > 0) idle(vecs[i].gap);
        end
        drain();

        // Backpressure: ten single-pair groups against a stalled consumer.
        res_ready = 1'b0;
        accepts = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    pa = i * 1234 - 5000;
                    pb = 77 - i * 9;
                    send(16'(pa), 16'(pb), 1'b1, 40'(pa * pb), 1'b0);
                end
            end
            begin
                repeat (20) @(negedge clk);
                chk("credit_accepts", 64'(accepts), 64'd4);
                chk("credit_op_ready", {63'd0, op_ready}, 64'd0);
                chk("credit_res_valid", {63'd0, res_valid}, 64'd1);
                @(posedge clk); #1;
                res_ready = 1'b1;
            end
        join
        drain();

        // Full FIFO with an intermittent consumer: pushes and pops overlap near full.
        res_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    pa = 300 - i * 97;
                    pb = -1000 + i * 333;
                    send(16'(pa), 16'(pb), 1'b1, 40'(pa * pb), 1'b0);
                end
            end
            begin
                repeat (8) @(negedge clk);
                chk("full_op_ready", {63'd0, op_ready}, 64'd0);
                @(posedge clk); #1;
                for (int j = 0; j < 30; j++) begin
                    res_ready = ~res_ready;
                    @(posedge clk); #1;
                end
                res_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-group with two products in flight: nothing may come out.
        send(16'd10, 16'd10, 1'b0, 40'd0, 1'b0);
        send(16'd20, 16'd20, 1'b0, 40'd0, 1'b0);
        send(16'd1, 16'd1, 1'b0, 40'd0, 1'b0);
        send(16'd1, 16'd1, 1'b0, 40'd0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_op_ready", {63'd0, op_ready}, 64'd1);
        chk("midrst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("midrst_res_data", {24'd0, res_data}, 64'd0);
        @(posedge clk); #1;
        idle(5);
        send(16'd2, 16'd3, 1'b1, 40'd6, 1'b0);
        drain();

        // Narrow accumulator: positive then negative saturation, then a clean group.
        for (int i = 0; i < 4; i++) send2(16'h8000, 16'h8000, (i == 3));
        expect2("sat_pos", 33'h0_FFFF_FFFF, 1'b1);
        send2(16'd1, 16'd1, 1'b1);
        expect2("after_sat", 33'd1, 1'b0);
        for (int i = 0; i < 5; i++) send2(16'h8000, 16'h7FFF, (i == 4));
        expect2("sat_neg", 33'h1_0000_0000, 1'b1);
        send2(16'(-3), 16'd7, 1'b1);
        expect2("after_sat_neg", 33'(-21), 1'b0);

        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
